// File: rtl/ex_mul_div_unit_pkg.sv
// Shared MIPS definitions for the execute-stage multiply/divide unit:
// funct codes, FSM encoding and the default datapath width.
package mips_pkg;

  localparam int WIDTH = 32;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_t;

endpackage

// File: rtl/ex_mul_div_unit_if.sv
// D/E-buffer facing bundle of the multiply/divide unit.
// master = pipeline side, slave = the unit.
interface ex_mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             rType_i;
  logic [5:0]       funct_i;
  logic [WIDTH-1:0] rsData_i;
  logic [WIDTH-1:0] rtData_i;
  logic             flush_i;
  logic             stall_o;
  logic             busy_o;
  logic             mfValid_o;
  logic [WIDTH-1:0] mfData_o;

  modport master (
    output rType_i, funct_i, rsData_i, rtData_i, flush_i,
    input  stall_o, busy_o, mfValid_o, mfData_o
  );

  modport slave (
    input  rType_i, funct_i, rsData_i, rtData_i, flush_i,
    output stall_o, busy_o, mfValid_o, mfData_o
  );
endinterface

// File: rtl/ex_mul_div_unit_md_datapath.sv
// Iterative unsigned shift-add multiplier / restoring divider, one step per enabled cycle.
// Operands load on load_i; results are valid after WIDTH steps and hold until the next load.
module md_datapath #(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               is_div_i,
  input  logic [WIDTH-1:0]   op_a_i,
  input  logic [WIDTH-1:0]   op_b_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0]   rem_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH:0]     sum, shifted, diff;

  always_comb begin
    acc_d   = acc_q;
    rem_d   = rem_q;
    opb_d   = opb_q;
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    shifted = {rem_q, acc_q[WIDTH-1]};
    // diff[WIDTH] is the borrow: set means the trial subtract is discarded
    diff    = shifted - {1'b0, opb_q};
    if (load_i) begin
      // low half holds the multiplier (mul) or the dividend shifting into the quotient (div)
      acc_d = {{WIDTH{1'b0}}, op_a_i};
      rem_d = '0;
      opb_d = op_b_i;
    end else if (step_i) begin
      if (is_div_i) begin
        if (diff[WIDTH]) begin
          rem_d                = shifted[WIDTH-1:0];
          acc_d[WIDTH-1:0]     = {acc_q[WIDTH-2:0], 1'b0};
        end else begin
          rem_d                = diff[WIDTH-1:0];
          acc_d[WIDTH-1:0]     = {acc_q[WIDTH-2:0], 1'b1};
        end
      end else begin
        acc_d = {sum, acc_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
      rem_q <= '0;
      opb_q <= '0;
    end else begin
      acc_q <= acc_d;
      rem_q <= rem_d;
      opb_q <= opb_d;
    end
  end

  assign acc_o = acc_q;
  assign rem_o = rem_q;

endmodule

// File: rtl/ex_mul_div_unit.sv
// Execute-stage MULT/MULTU/DIV/DIVU engine with HI/LO and MFHI/MFLO/MTHI/MTLO.
// Latency WIDTH+2 stalled cycles; stall_o freezes upstream, flush_i aborts without touching HI/LO.
module ex_mul_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH    = mips_pkg::WIDTH,
  parameter int CNT_BITS = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  ex_mul_div_unit_if.slave bus
);

  md_state_t           state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]    hi_q, hi_d, lo_q, lo_d;
  logic                is_div_q, is_div_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  logic                div0_q, div0_d;

  logic                is_md, is_signed, start, run_step;
  logic [WIDTH-1:0]    mag_a, mag_b, rem, quo_fix, rem_fix;
  logic [2*WIDTH-1:0]  acc, prod_fix;

  always_comb begin
    is_md     = bus.rType_i && (bus.funct_i == FUNCT_MULT || bus.funct_i == FUNCT_MULTU ||
                                bus.funct_i == FUNCT_DIV  || bus.funct_i == FUNCT_DIVU);
    is_signed = (bus.funct_i == FUNCT_MULT) || (bus.funct_i == FUNCT_DIV);
    // reset gate keeps stall_o low while rst_i is asserted even if an op is presented
    start     = is_md && (state_q == IDLE) && !bus.flush_i && !rst_i;
    run_step  = (state_q == RUN);
    mag_a     = (is_signed && bus.rsData_i[WIDTH-1]) ? -bus.rsData_i : bus.rsData_i;
    mag_b     = (is_signed && bus.rtData_i[WIDTH-1]) ? -bus.rtData_i : bus.rtData_i;
    prod_fix  = neg_res_q ? -acc : acc;
    // divide by zero leaves the all-ones quotient alone regardless of operand signs
    quo_fix   = (neg_res_q && !div0_q) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix   = neg_rem_q ? -rem : rem;

    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          cnt_d     = CNT_BITS'(WIDTH);
          is_div_d  = bus.funct_i[1];
          neg_res_d = is_signed && (bus.rsData_i[WIDTH-1] ^ bus.rtData_i[WIDTH-1]);
          neg_rem_d = is_signed && bus.rsData_i[WIDTH-1];
          div0_d    = (bus.rtData_i == '0);
        end else if (bus.rType_i && bus.funct_i == FUNCT_MTHI) begin
          hi_d = bus.rsData_i;
        end else if (bus.rType_i && bus.funct_i == FUNCT_MTLO) begin
          lo_d = bus.rsData_i;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_BITS'(1);
        if (cnt_q == CNT_BITS'(1)) state_d = FIX;
      end
      FIX: begin
        state_d = DONE;
        if (is_div_q) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && bus.flush_i) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
    end
  end

  md_datapath #(.WIDTH(WIDTH)) u_md_datapath (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (start),
    .step_i   (run_step),
    .is_div_i (is_div_q),
    .op_a_i   (mag_a),
    .op_b_i   (mag_b),
    .acc_o    (acc),
    .rem_o    (rem)
  );

  assign bus.stall_o   = start || (((state_q == RUN) || (state_q == FIX)) && !bus.flush_i);
  assign bus.busy_o    = (state_q != IDLE);
  assign bus.mfValid_o = bus.rType_i && (bus.funct_i == FUNCT_MFHI || bus.funct_i == FUNCT_MFLO)
                         && !bus.stall_o;
  assign bus.mfData_o  = (bus.funct_i == FUNCT_MFLO) ? lo_q : hi_q;

endmodule
